// File: rtl/mult_wb_buffer_pkg.sv
// Shared constants for the multiply write-back buffer.
//   MULT_PPL_STAGE : multiplier pipeline depth (>= 2); sets the stall threshold
//   REG_AW         : register-file address width
//   XLEN           : register data width
//   NREG           : number of architectural registers (width of pend vectors)
package mult_wb_buffer_pkg;
    localparam int MULT_PPL_STAGE = 4;
    localparam int REG_AW         = 5;
    localparam int XLEN           = 32;
    localparam int NREG           = 1 << REG_AW;
endpackage

// File: rtl/mult_wb_buffer_fifo.sv
// mult_wb_fifo: in-order storage of multiply results awaiting the RF write port.
// Each entry holds {valid, rd, data}. Entries can be invalidated in place by a
// squash-by-address; invalid entries still occupy a slot until popped.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   push_i/_rd_i/_data_i  enqueue at tail (caller guarantees room or a same-cycle pop)
//   pop_i               dequeue head (caller guarantees count_o != 0)
//   squash_i/_rd_i      clear valid of every entry whose rd matches
//   head_valid_o/_rd_o/_data_o  current head entry
//   any_valid_o         at least one valid entry is stored
//   pend_vec_o          one-hot OR of rd over valid entries (bit 0 forced 0)
//   count_o             occupancy including squashed entries
module mult_wb_fifo
    import mult_wb_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [REG_AW-1:0] push_rd_i,
    input  logic [XLEN-1:0]   push_data_i,
    input  logic              pop_i,
    input  logic              squash_i,
    input  logic [REG_AW-1:0] squash_rd_i,
    output logic              head_valid_o,
    output logic [REG_AW-1:0] head_rd_o,
    output logic [XLEN-1:0]   head_data_o,
    output logic              any_valid_o,
    output logic [NREG-1:0]   pend_vec_o,
    output logic [CNT_W-1:0]  count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              valid_q [DEPTH];
    logic [REG_AW-1:0] rd_q    [DEPTH];
    logic [XLEN-1:0]   data_q  [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [NREG-1:0]   ent_vec [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        head_d  = pop_i  ? ptr_inc(head_q) : head_q;
        tail_d  = push_i ? ptr_inc(tail_q) : tail_q;
        count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    // Valid bits: squash first, then pop clears the head, then a push sets
    // the tail. When full with push+pop, tail == head and the push wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash_i && valid_q[i] && (rd_q[i] == squash_rd_i))
                    valid_q[i] <= 1'b0;
            end
            if (pop_i)  valid_q[head_q] <= 1'b0;
            if (push_i) valid_q[tail_q] <= 1'b1;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset; it is only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (push_i) begin
            rd_q[tail_q]   <= push_rd_i;
            data_q[tail_q] <= push_data_i;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
            assign ent_vec[gi] = valid_q[gi] ? (NREG'(1) << rd_q[gi]) : '0;
        end
    endgenerate

    always_comb begin
        pend_vec_o  = '0;
        any_valid_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_vec_o  = pend_vec_o | ent_vec[i];
            any_valid_o = any_valid_o | valid_q[i];
        end
        pend_vec_o[0] = 1'b0;
    end

    assign head_valid_o = valid_q[head_q];
    assign head_rd_o    = rd_q[head_q];
    assign head_data_o  = data_q[head_q];
    assign count_o      = count_q;
endmodule

// File: rtl/mult_wb_buffer.sv
// mult_wb_buffer: arbitrates the single register-file write port between the
// main pipeline MEM/WB write and completed multiply results, buffering losers.
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   mult_valid_i/_rd_addr_i/_rd_data_i  last-stage multiply result
//   wb_we_i/_addr_i/_data_i   main pipeline write
//   rf_we_o/_waddr_o/_wdata_o register-file write port
//   pend_vec_o                registers targeted by valid buffered entries
//   count_o                   buffer occupancy (valid + squashed entries)
//   stall_o                   freeze multiply issue (from registered count)
//   overflow_o                sticky: a result was dropped on a full buffer
module mult_wb_buffer
    import mult_wb_buffer_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int PPL_STAGES = MULT_PPL_STAGE,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mult_valid_i,
    input  logic [REG_AW-1:0] mult_rd_addr_i,
    input  logic [XLEN-1:0]   mult_rd_data_i,
    input  logic              wb_we_i,
    input  logic [REG_AW-1:0] wb_addr_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic              rf_we_o,
    output logic [REG_AW-1:0] rf_waddr_o,
    output logic [XLEN-1:0]   rf_wdata_o,
    output logic [NREG-1:0]   pend_vec_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              stall_o,
    output logic              overflow_o
);
    logic              wb_eff, mult_eff, same_rd, bypass;
    logic              want_push, push, pop, full, ovf_set;
    logic              head_valid, any_valid;
    logic [REG_AW-1:0] head_rd;
    logic [XLEN-1:0]   head_data;
    logic [NREG-1:0]   fifo_pend;
    logic [CNT_W-1:0]  count;
    logic              we_d;
    logic [REG_AW-1:0] waddr_d;
    logic [XLEN-1:0]   wdata_d;
    logic              overflow_q, overflow_d;

    assign wb_eff   = wb_we_i && (wb_addr_i != '0);
    assign mult_eff = mult_valid_i && (mult_rd_addr_i != '0);
    // The concurrent multiply is older than the WB instruction, so its result
    // to the same register is dead.
    assign same_rd  = wb_eff && (mult_rd_addr_i == wb_addr_i);
    assign full     = (count == CNT_W'(DEPTH));

    always_comb begin
        we_d      = 1'b0;
        waddr_d   = '0;
        wdata_d   = '0;
        bypass    = 1'b0;
        // Squashed heads drain regardless of port ownership.
        pop       = (count != '0) && (!head_valid || !wb_eff);
        if (wb_eff) begin
            we_d    = 1'b1;
            waddr_d = wb_addr_i;
            wdata_d = wb_data_i;
        end else if (head_valid) begin
            we_d    = 1'b1;
            waddr_d = head_rd;
            wdata_d = head_data;
        end else if (mult_eff && !any_valid) begin
            bypass  = 1'b1;
            we_d    = 1'b1;
            waddr_d = mult_rd_addr_i;
            wdata_d = mult_rd_data_i;
        end
        want_push  = mult_eff && !same_rd && !bypass;
        push       = want_push && (!full || pop);
        ovf_set    = want_push && full && !pop;
        overflow_d = overflow_q | ovf_set;
    end

    mult_wb_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_rd_i    (mult_rd_addr_i),
        .push_data_i  (mult_rd_data_i),
        .pop_i        (pop),
        .squash_i     (wb_eff),
        .squash_rd_i  (wb_addr_i),
        .head_valid_o (head_valid),
        .head_rd_o    (head_rd),
        .head_data_o  (head_data),
        .any_valid_o  (any_valid),
        .pend_vec_o   (fifo_pend),
        .count_o      (count)
    );

    always_ff @(posedge clk) begin
        if (!rst) overflow_q <= 1'b0;
        else      overflow_q <= overflow_d;
    end

    // Outputs are held quiet while reset is asserted.
    assign rf_we_o    = rst && we_d;
    assign rf_waddr_o = rst ? waddr_d : '0;
    assign rf_wdata_o = rst ? wdata_d : '0;
    assign pend_vec_o = rst ? fifo_pend : '0;
    assign count_o    = count;
    assign stall_o    = rst && (count >= CNT_W'(DEPTH - PPL_STAGES));
    assign overflow_o = overflow_q;
endmodule

// File: tb/tb_mult_wb_buffer.sv
module tb_mult_wb_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        mult_valid_i;
    logic [4:0]  mult_rd_addr_i;
    logic [31:0] mult_rd_data_i;
    logic        wb_we_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [31:0] pend_vec_o;
    logic [3:0]  count_o;
    logic        stall_o;
    logic        overflow_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_wb_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .mult_valid_i   (mult_valid_i),
        .mult_rd_addr_i (mult_rd_addr_i),
        .mult_rd_data_i (mult_rd_data_i),
        .wb_we_i        (wb_we_i),
        .wb_addr_i      (wb_addr_i),
        .wb_data_i      (wb_data_i),
        .rf_we_o        (rf_we_o),
        .rf_waddr_o     (rf_waddr_o),
        .rf_wdata_o     (rf_wdata_o),
        .pend_vec_o     (pend_vec_o),
        .count_o        (count_o),
        .stall_o        (stall_o),
        .overflow_o     (overflow_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One transaction: drive just after a rising edge, sample at the falling edge.
    task automatic cyc(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
        @(posedge clk);
        #1;
        mult_valid_i   = mv;
        mult_rd_addr_i = mrd;
        mult_rd_data_i = md;
        wb_we_i        = we;
        wb_addr_i      = wa;
        wb_data_i      = wd;
        @(negedge clk);
        $display("t=%0t mult(%0b x%0d %h) wb(%0b x%0d %h) -> rf(%0b x%0d %h) cnt=%0d stall=%0b pend=%h ovf=%0b",
                 $time, mv, mrd, md, we, wa, wd, rf_we_o, rf_waddr_o, rf_wdata_o,
                 count_o, stall_o, pend_vec_o, overflow_o);
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic chk_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_we"}, 32'(rf_we_o), 32'(we));
        if (we) begin
            chk({tag, "_addr"}, 32'(rf_waddr_o), 32'(a));
            chk({tag, "_data"}, rf_wdata_o, d);
        end
    endtask

    initial begin
        rst = 1'b0;
        mult_valid_i = 0; mult_rd_addr_i = 0; mult_rd_data_i = 0;
        wb_we_i = 0; wb_addr_i = 0; wb_data_i = 0;

        // Reset
        idle();
        idle();
        chk("rst_we", 32'(rf_we_o), 0);
        chk("rst_cnt", 32'(count_o), 0);
        chk("rst_stall", 32'(stall_o), 0);
        chk("rst_pend", pend_vec_o, 0);
        chk("rst_ovf", 32'(overflow_o), 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Bypass
        cyc(1, 5'd5, 32'h0000_1234, 0, 0, 0);
        chk_rf("byp", 1, 5'd5, 32'h0000_1234);
        idle();
        chk("byp_cnt", 32'(count_o), 0);
        chk_rf("byp_idle", 0, 0, 0);

        // Concurrent: wb wins, mult buffered
        cyc(1, 5'd6, 32'hAAAA_0001, 1, 5'd7, 32'h55);
        chk_rf("conc_wb", 1, 5'd7, 32'h55);
        idle();
        chk("conc_cnt", 32'(count_o), 1);
        chk("conc_pend", pend_vec_o, 32'h0000_0040);
        chk_rf("conc_drain", 1, 5'd6, 32'hAAAA_0001);
        idle();
        chk("conc_cnt0", 32'(count_o), 0);
        chk("conc_pend0", pend_vec_o, 0);

        // Four multiplies behind continuous wb writes, then drain in order
        for (int i = 0; i < 4; i++) begin
            cyc(1, 5'(8 + i), 32'h100 + i, 1, 5'd1, 32'(i));
            chk_rf("burst_wb", 1, 5'd1, 32'(i));
        end
        idle();
        chk("burst_cnt", 32'(count_o), 4);
        chk("burst_stall", 32'(stall_o), 1);
        chk("burst_pend", pend_vec_o, 32'h0000_0F00);
        chk_rf("burst_d0", 1, 5'd8, 32'h100);
        for (int i = 1; i < 4; i++) begin
            idle();
            chk("burst_stall_lo", 32'(stall_o), 0);
            chk_rf("burst_dn", 1, 5'(8 + i), 32'h100 + i);
        end
        idle();
        chk("burst_cnt0", 32'(count_o), 0);
        chk_rf("burst_end", 0, 0, 0);

        // Squash of a buffered entry
        cyc(1, 5'd12, 32'hDEAD_BEEF, 1, 5'd2, 32'h22);
        cyc(0, 0, 0, 1, 5'd12, 32'h99);
        chk("sq_pend_pre", pend_vec_o, 32'h0000_1000);
        chk_rf("sq_wb", 1, 5'd12, 32'h99);
        idle();
        chk("sq_pend", pend_vec_o, 0);
        chk("sq_cnt", 32'(count_o), 1);
        chk_rf("sq_nowrite", 0, 0, 0);
        idle();
        chk("sq_cnt0", 32'(count_o), 0);
        chk_rf("sq_nowrite2", 0, 0, 0);

        // Same-cycle squash of the incoming multiply
        cyc(1, 5'd13, 32'h1313, 1, 5'd13, 32'h42);
        chk_rf("sqin_wb", 1, 5'd13, 32'h42);
        idle();
        chk("sqin_cnt", 32'(count_o), 0);
        chk_rf("sqin_none", 0, 0, 0);

        // rd = 0 multiply dropped; wb to x0 ineffective -> bypass
        cyc(1, 5'd0, 32'h1111, 0, 0, 0);
        chk_rf("x0_mult", 0, 0, 0);
        idle();
        chk("x0_cnt", 32'(count_o), 0);
        cyc(1, 5'd3, 32'h3333, 1, 5'd0, 32'h77);
        chk_rf("x0_wb", 1, 5'd3, 32'h3333);
        idle();
        chk("x0_cnt2", 32'(count_o), 0);

        // Overflow: nine pushes with wb always busy
        for (int i = 0; i < 9; i++) begin
            cyc(1, 5'(16 + i), 32'h1600 + i, 1, 5'd1, 32'hF0 + i);
            chk_rf("ovf_wb", 1, 5'd1, 32'hF0 + i);
        end
        idle();
        chk("ovf_cnt", 32'(count_o), 8);
        chk("ovf_flag", 32'(overflow_o), 1);
        chk("ovf_stall", 32'(stall_o), 1);
        chk("ovf_pend", pend_vec_o, 32'h00FF_0000);
        chk_rf("ovf_d0", 1, 5'd16, 32'h1600);
        idle();
        chk("ovf_sticky", 32'(overflow_o), 1);
        chk("ovf_cnt7", 32'(count_o), 7);

        // Mid-operation reset
        @(posedge clk);
        #1 rst = 1'b0;
        mult_valid_i = 0; wb_we_i = 0;
        @(negedge clk);
        chk("mrst_we", 32'(rf_we_o), 0);
        chk("mrst_pend", pend_vec_o, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mrst_cnt", 32'(count_o), 0);
        chk("mrst_ovf", 32'(overflow_o), 0);
        chk("mrst_stall", 32'(stall_o), 0);
        chk("mrst_pend2", pend_vec_o, 0);
        chk("mrst_we2", 32'(rf_we_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_wb_buffer.md
Name: mult_wb_buffer

Overview:
Downstream of the pipelined multiplier manager. It captures each completed multiply result (last pipeline stage) and arbitrates the single register-file write port against the main pipeline's MEM/WB write. Multiply results that lose arbitration are held in a small in-order buffer. The block also exports a stall request and a pending-destination bitmap to the multiplier stall control.

Parameters:
DEPTH, 8, number of buffer entries; must exceed MULT_PPL_STAGE.
MULT_PPL_STAGE, `MULT_PPL_STAGE (4), multiplier pipeline depth; must be >= 2; sets the stall threshold.
CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-low reset.
mult_valid_i  input  1  multiply result valid (last-stage use bit).
mult_rd_addr_i  input  5  multiply destination register.
mult_rd_data_i  input  32  multiply result.
wb_we_i  input  1  main pipeline write enable.
wb_addr_i  input  5  main pipeline destination register.
wb_data_i  input  32  main pipeline write data.
rf_we_o  output  1  register-file write enable.
rf_waddr_o  output  5  register-file write address.
rf_wdata_o  output  32  register-file write data.
pend_vec_o  output  32  bit r = 1 if a valid buffered entry targets xr; bit 0 is always 0.
count_o  output  CNT_W  buffer occupancy, counting valid and squashed entries.
stall_o  output  1  request to freeze multiply issue.
overflow_o  output  1  sticky error flag.

Behaviour:
- Reset (rst = 0 at a clock edge): count = 0, all entry valid bits cleared, head/tail pointers = 0, overflow_o = 0.
- Outputs during and after reset: rf_we_o = 0, rf_waddr_o = 0, rf_wdata_o = 0, pend_vec_o = 0, stall_o = 0.
- A reset asserted mid-operation discards all buffered results with no write.

Write qualification:
- The main pipeline write is effective when wb_we_i = 1 and wb_addr_i != 0.
- The multiply input is effective when mult_valid_i = 1 and mult_rd_addr_i != 0. A multiply result with rd = 0 is dropped silently.

Write-port priority, evaluated each cycle; rf_* outputs are combinational from registered state and inputs:
1. An effective main pipeline write wins the port.
2. Otherwise, if the head entry is valid, write the head and pop it.
3. Otherwise, if the buffer holds no valid entries, write an effective multiply input directly (0-cycle bypass, no enqueue).
- An effective multiply input that does not get the port is enqueued at the tail. Program order is preserved and a multiply never overtakes an older buffered entry.

Squash (WAW ordering):
- A concurrent multiply result is always older than the main WB instruction, because MULT_PPL_STAGE >= 2.
- On an effective main write to X, clear the valid bit of every buffered entry with rd = X in the same cycle.
- In that same cycle, an incoming multiply with rd = X is dropped (not enqueued, not written).

Squashed-entry drain:
- A head entry with valid = 0 is popped without a write, one per cycle, regardless of who owns the port.

Occupancy and pointers:
- count_next = count + push − pop; a simultaneous push and pop leaves count unchanged.
- Pointers wrap modulo DEPTH.

Flow control:
- stall_o = (count >= DEPTH − MULT_PPL_STAGE), registered count only. This guarantees room for every in-flight multiply.
- A push when count = DEPTH and no pop is happening that cycle: the result is dropped and overflow_o is set to 1, cleared only by reset.

pend_vec_o:
- OR of one-hot(rd) over valid entries, computed from registered state.
- It does not include the current-cycle incoming multiply; stall control already sees that through the multiplier's per-stage rd_addrs.

Decomposition:
- Shared defines header: MULT_PPL_STAGE, the register address width (5), and XLEN (32).
- One natural sub-module, mult_wb_fifo: entry storage {valid, rd, data}, pointers, count, and a squash-by-address input.
- The arbiter, stall and flag logic stay in the top level.

Test Plan:
- Reset, then a multiply (rd = 5, data 0x0000_1234) with wb idle -> rf write x5 = 0x1234 in the same cycle; count_o stays 0.
- Multiply (rd = 6, 0xAAAA_0001) concurrent with wb (x7 = 0x55) -> x7 written that cycle, multiply buffered, pend_vec_o[6] = 1 next cycle; x6 written the following cycle.
- Continuous wb writes to x1 plus 4 multiplies (rd = 8..11) -> count_o reaches 4, stall_o = 1; wb stops -> x8, x9, x10, x11 written in order, then stall_o = 0.
- Buffer holds rd = 12; wb writes x12 = 0x99 -> entry squashed, pend_vec_o[12] = 0, x12 is never overwritten by the multiply value.
- A multiply with rd = 0 -> no write, count_o unchanged; wb to x0 with a multiply rd = 3 pending -> the multiply bypasses to x3.
- Force 9 pushes with wb always busy (stall ignored) -> overflow_o = 1 and stays 1; rst = 0 for one cycle -> all outputs and count_o return to 0.
